fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 30'h0000000, SHALL be the word address fetched first after reset.
REQ-002 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 i_rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 i_stall  input  1  SHALL mean the consumer cannot take the held instruction this cycle.
REQ-005 i_redirect  input  1  SHALL be the one-cycle next-PC select pulse (branch taken or jump).
REQ-006 i_redirect_pc  input  30  SHALL be the redirect target word address, valid with i_redirect.
REQ-007 i_imem_ack  input  1  SHALL mean the memory returns data for the outstanding request.
REQ-008 i_imem_data  input  32  SHALL be the instruction word, valid with i_imem_ack.
REQ-009 o_imem_req  output  1  SHALL be the registered memory request.
REQ-010 o_imem_addr  output  30  SHALL be the registered request word address.
REQ-011 o_instr  output  32  SHALL be the held instruction.
REQ-012 o_instr_pc  output  30  SHALL be the word address of o_instr.
REQ-013 o_instr_valid  output  1  SHALL mean o_instr/o_instr_pc are valid.
REQ-014 o_pc_plus1  output  30  SHALL equal o_instr_pc + 1 mod 2^30, combinationally.

Function
REQ-015 Internal state SHALL be: pc (30 b), discard flag, FSM {IDLE, WAIT, HOLD}.
REQ-016 Memory handshake: o_imem_req and o_imem_addr SHALL be held constant from assertion until the cycle i_imem_ack=1; ack arrives at least 1 cycle after req rises.
REQ-017 IDLE: req=0, valid=0; next edge SHALL set req<=1, o_imem_addr<=pc (or i_redirect_pc if i_redirect=1, also loaded into pc), go WAIT.
REQ-018 WAIT, ack=1, discard=0, i_redirect=0: SHALL capture o_instr<=i_imem_data, o_instr_pc<=o_imem_addr, valid<=1, req<=0, pc<=o_imem_addr+1, go HOLD.
REQ-019 WAIT, ack=1, discard=1 or i_redirect=1: SHALL drop data (valid stays 0), discard<=0, keep req=1 with o_imem_addr<=(i_redirect ? i_redirect_pc : pc), pc<=same value, stay WAIT.
REQ-020 WAIT, ack=0, i_redirect=1: SHALL set pc<=i_redirect_pc, discard<=1; req/addr unchanged.
REQ-021 WAIT SHALL ignore i_stall.
REQ-022 HOLD, i_redirect=1 (priority over stall): SHALL flush valid<=0, pc<=i_redirect_pc, req<=1, o_imem_addr<=i_redirect_pc, go WAIT.
REQ-023 HOLD, i_redirect=0, i_stall=0: instruction consumed; SHALL set valid<=0, req<=1, o_imem_addr<=pc, go WAIT.
REQ-024 HOLD, i_redirect=0, i_stall=1: SHALL hold all outputs, req=0.
REQ-025 Throughput SHALL be one instruction per (ack latency + 2) cycles minimum; at most one request outstanding.
REQ-026 pc increment SHALL wrap 30'h3FFFFFFF -> 30'h0000000; o_pc_plus1 likewise.
REQ-027 Consecutive redirects in WAIT SHALL keep only the last target; discard stays 1 until the ack.

Reset
REQ-028 While i_rst=1: state=IDLE, pc=RESET_PC, discard=0, o_imem_req=0, o_imem_addr=0, o_instr=0, o_instr_pc=0, o_instr_valid=0, immediately.
REQ-029 Reset asserted in WAIT SHALL abandon the outstanding request; an ack arriving during or after reset with state IDLE SHALL be ignored.
REQ-030 First request SHALL assert on the second rising edge after i_rst deasserts (one IDLE cycle).

Verification
REQ-031 Reset release, RESET_PC=0, ack latency 1, stall=0 -> fetch addresses 0,1,2,... ; valid pulses every 3 cycles; o_pc_plus1 = addr+1.
REQ-032 Held in HOLD with i_stall=1 for 5 cycles, o_instr=32'h8C010004 -> outputs stable, req=0 for 5 cycles; stall=0 -> next req at addr+1.
REQ-033 Redirect to 30'h100 in WAIT, ack latency 3 -> pending data dropped, next request at 30'h100, o_instr_pc=30'h100.
REQ-034 Redirect to 30'h40 coincident with ack -> no valid, req re-issued at 30'h40 next cycle.
REQ-035 Redirect in HOLD with i_stall=1 -> valid drops next cycle, req at target.
REQ-036 pc=30'h3FFFFFFF fetched -> next request at 30'h0000000; i_rst pulsed mid-WAIT -> all outputs zero, later ack ignored, restart at RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: single outstanding memory request, holds one
// fetched instruction for the consumer, supports redirects at any point.
module fetch_sequencer #(
  parameter logic [29:0] RESET_PC = 30'h0000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [29:0] i_redirect_pc,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic        o_imem_req,
  output logic [29:0] o_imem_addr,
  output logic [31:0] o_instr,
  output logic [29:0] o_instr_pc,
  output logic        o_instr_valid,
  output logic [29:0] o_pc_plus1
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t      state, state_n;
  logic [29:0] pc, pc_n, addr_n, ipc_n, tgt;
  logic [31:0] instr_n;
  logic        discard, discard_n, req_n, vld_n;
  logic        boot;

  assign o_pc_plus1 = o_instr_pc + 30'd1;
  assign tgt        = i_redirect ? i_redirect_pc : pc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      discard       <= 1'b0;
      boot          <= 1'b1;
      o_imem_req    <= 1'b0;
      o_imem_addr   <= '0;
      o_instr       <= '0;
      o_instr_pc    <= '0;
      o_instr_valid <= 1'b0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      discard       <= discard_n;
      boot          <= 1'b0;
      o_imem_req    <= req_n;
      o_imem_addr   <= addr_n;
      o_instr       <= instr_n;
      o_instr_pc    <= ipc_n;
      o_instr_valid <= vld_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    req_n     = o_imem_req;
    addr_n    = o_imem_addr;
    instr_n   = o_instr;
    ipc_n     = o_instr_pc;
    vld_n     = o_instr_valid;
    case (state)
      IDLE: begin
        // boot keeps IDLE for one full cycle after reset release
        if (!boot) begin
          req_n   = 1'b1;
          addr_n  = tgt;
          pc_n    = tgt;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (i_imem_ack) begin
          if (discard || i_redirect) begin
            discard_n = 1'b0;
            req_n     = 1'b1;
            addr_n    = tgt;
            pc_n      = tgt;
          end else begin
            instr_n = i_imem_data;
            ipc_n   = o_imem_addr;
            vld_n   = 1'b1;
            req_n   = 1'b0;
            pc_n    = o_imem_addr + 30'd1;
            state_n = HOLD;
          end
        end else if (i_redirect) begin
          // request already in flight: remember target, drop its data later
          pc_n      = i_redirect_pc;
          discard_n = 1'b1;
        end
      end
      HOLD: begin
        if (i_redirect) begin
          vld_n   = 1'b0;
          pc_n    = i_redirect_pc;
          req_n   = 1'b1;
          addr_n  = i_redirect_pc;
          state_n = WAIT;
        end else if (!i_stall) begin
          vld_n   = 1'b0;
          req_n   = 1'b1;
          addr_n  = pc;
          state_n = WAIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
